serial_add_sequencer: RTL and testbench

Sequencer that owns one bit-serial full-adder slice and runs WIDTH-bit add/subtract operations through it LSB-first. Operands and opcode are accepted by a valid/ready handshake, shifted one bit per cycle through the slice, and the result is collected in a shift register. The result is presented with carry-out and signed-overflow flags on a second valid/ready handshake. It sits between a command source and the consumer of arithmetic results, trading WIDTH cycles of latency for a single 1-bit adder.

---
 rtl/serial_add_pkg.sv | 10 +
 rtl/serial_add_if.sv | 25 ++
 rtl/serial_fa_slice.sv | 36 +++
 rtl/serial_add_sequencer.sv | 92 +++++++++
 tb/tb_serial_add_sequencer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state encoding and sizing helper for the bit-serial adder
package serial_add_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_add_if.sv
// serial_add_if: operation request and result handshakes of the serial adder
interface serial_add_if #(parameter int WIDTH = 8);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_carry, out_ovf
    );

endinterface

// File: rtl/serial_fa_slice.sv
// serial_fa_slice: one-bit full adder with its registered carry
module serial_fa_slice (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic load_val,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry_in_q,
    output logic carry_q
);

    logic r_carry;
    logic w_cout;

    // gate-level full adder fed by the registered carry
    always_comb begin
        sum        = a ^ b ^ r_carry;
        w_cout     = (a & b) | (r_carry & (a ^ b));
        carry_in_q = r_carry;
        carry_q    = r_carry;
    end

    // carry flop: load seeds the chain, en advances it one bit
    always_ff @(posedge clk) begin
        if (rst)
            r_carry <= 1'b0;
        else if (load)
            r_carry <= load_val;
        else if (en)
            r_carry <= w_cout;
    end

endmodule

// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: runs WIDTH-bit add/sub LSB-first through one full-adder slice
module serial_add_sequencer
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    serial_add_if.slave bus
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_c_msb_in;
    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic             w_sum;
    logic             w_carry_in_q;
    logic             w_carry_q;

    serial_fa_slice u_slice (
        .clk        (clk),
        .rst        (rst),
        .load       (w_accept),
        .load_val   (bus.in_sub),
        .en         (w_run),
        .a          (r_a[0]),
        .b          (r_b[0]),
        .sum        (w_sum),
        .carry_in_q (w_carry_in_q),
        .carry_q    (w_carry_q)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // next state: accept -> WIDTH run cycles -> hold result until consumed
    always_comb begin
        w_next = (r_state == IDLE && bus.in_valid)  ? RUN  :
                 (r_state == RUN  && w_last)        ? DONE :
                 (r_state == DONE && bus.out_ready) ? IDLE : r_state;
    end

    // handshake outputs and slice control decoded from state
    always_comb begin
        bus.in_ready  = (r_state == IDLE);
        bus.out_valid = (r_state == DONE);
        w_accept      = (r_state == IDLE) && bus.in_valid;
        w_run         = (r_state == RUN);
        w_last        = (r_state == RUN) && (r_cnt == LAST);
        bus.out_sum   = r_res;
        bus.out_carry = w_carry_q;
        bus.out_ovf   = r_c_msb_in ^ w_carry_q;
    end

    // operand/result shifters, bit counter and MSB carry-in capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_res      <= '0;
            r_cnt      <= '0;
            r_c_msb_in <= 1'b0;
        end else if (w_accept) begin
            r_a   <= bus.in_a;
            r_b   <= bus.in_sub ? ~bus.in_b : bus.in_b;
            r_cnt <= '0;
        end else if (w_run) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_res <= {w_sum, r_res[WIDTH-1:1]};
            if (w_last)
                r_c_msb_in <= w_carry_in_q;
            else
                r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb_serial_add_sequencer: directed and randomized checks of the serial adder
module tb_serial_add_sequencer;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    serial_add_if #(.WIDTH(W)) bus ();

    serial_add_sequencer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_sum, bus.out_carry, bus.out_ovf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_held: rdy=%b vld=%b sum=%h c=%b v=%b, expected rdy=1 vld=0 sum=00 c=0 v=0",
                     bus.in_ready, bus.out_valid, bus.out_sum, bus.out_carry, bus.out_ovf);
        end
        rst = 1'b0;
        step();
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_sum} !== {1'b1, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_release: rdy=%b vld=%b sum=%h, expected rdy=1 vld=0 sum=00",
                     bus.in_ready, bus.out_valid, bus.out_sum);
        end
    endtask

    task automatic test_vectors();
        logic [W-1:0] va [4] = '{8'h5A, 8'hFF, 8'h10, 8'h80};
        logic [W-1:0] vb [4] = '{8'h3C, 8'h01, 8'h20, 8'h01};
        logic         vs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] es [4] = '{8'h96, 8'h00, 8'hF0, 8'h7F};
        logic         ec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic         eo [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            bus.in_a = va[i];
            bus.in_b = vb[i];
            bus.in_sub = vs[i];
            bus.in_valid = 1'b1;
            bus.out_ready = 1'b1;
            n_checks++;
            if (bus.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL vec%0d_ready: in_ready=%b, expected 1", i, bus.in_ready);
            end
            step();
            bus.in_valid = 1'b0;
            repeat (W - 1) step();
            n_checks++;
            if ({bus.out_valid, bus.in_ready} !== 2'b00) begin
                n_fail++;
                $display("FAIL vec%0d_early: vld=%b rdy=%b at T+%0d, expected 0 0", i, bus.out_valid, bus.in_ready, W);
            end
            step();
            n_checks++;
            if ({bus.out_valid, bus.out_sum, bus.out_carry, bus.out_ovf} !== {1'b1, es[i], ec[i], eo[i]}) begin
                n_fail++;
                $display("FAIL vec%0d_result: vld=%b sum=%h c=%b v=%b, expected vld=1 sum=%h c=%b v=%b",
                         i, bus.out_valid, bus.out_sum, bus.out_carry, bus.out_ovf, es[i], ec[i], eo[i]);
            end
            step();
            n_checks++;
            if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
                n_fail++;
                $display("FAIL vec%0d_handshake: rdy=%b vld=%b, expected 1 0", i, bus.in_ready, bus.out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        bus.in_a = 8'h33;
        bus.in_b = 8'h11;
        bus.in_sub = 1'b0;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        step();
        bus.in_a = 8'h0F;
        bus.in_b = 8'h01;
        bus.in_sub = 1'b1;
        repeat (W) step();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({bus.out_valid, bus.in_ready, bus.out_sum, bus.out_carry, bus.out_ovf} !== {1'b1, 1'b0, 8'h44, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: vld=%b rdy=%b sum=%h c=%b v=%b, expected vld=1 rdy=0 sum=44 c=0 v=0",
                         i, bus.out_valid, bus.in_ready, bus.out_sum, bus.out_carry, bus.out_ovf);
            end
            step();
        end
        bus.out_ready = 1'b1;
        step();
        n_checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_release: rdy=%b vld=%b, expected 1 0", bus.in_ready, bus.out_valid);
        end
        step();
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_second_accept: rdy=%b, expected 0", bus.in_ready);
        end
        repeat (W) step();
        n_checks++;
        if ({bus.out_valid, bus.out_sum, bus.out_carry, bus.out_ovf} !== {1'b1, 8'h0E, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_second_result: vld=%b sum=%h c=%b v=%b, expected vld=1 sum=0e c=1 v=0",
                     bus.out_valid, bus.out_sum, bus.out_carry, bus.out_ovf);
        end
        step();
    endtask

    task automatic test_rst_mid_run();
        bus.in_a = 8'hAA;
        bus.in_b = 8'h55;
        bus.in_sub = 1'b0;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_sum, bus.out_carry, bus.out_ovf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_run_state: rdy=%b vld=%b sum=%h c=%b v=%b, expected rdy=1 vld=0 sum=00 c=0 v=0",
                     bus.in_ready, bus.out_valid, bus.out_sum, bus.out_carry, bus.out_ovf);
        end
        for (int i = 0; i < W + 2; i++) begin
            if (bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_run_no_pulse: vld=%b at cycle %0d, expected 0", bus.out_valid, i);
            end
            step();
        end
        n_checks++;
        bus.in_a = 8'h01;
        bus.in_b = 8'h01;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (W) step();
        n_checks++;
        if ({bus.out_valid, bus.out_sum, bus.out_carry, bus.out_ovf} !== {1'b1, 8'h02, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_run_fresh_op: vld=%b sum=%h c=%b v=%b, expected vld=1 sum=02 c=0 v=0",
                     bus.out_valid, bus.out_sum, bus.out_carry, bus.out_ovf);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b;
        logic         sub, exp_v, done;
        logic [W:0]   full;
        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            sub = 1'($urandom_range(0, 1));
            full = sub ? ({1'b0, a} + {1'b0, ~b} + 1'b1) : ({1'b0, a} + {1'b0, b});
            exp_v = sub ? ((a[W-1] != b[W-1]) && (full[W-1] != a[W-1]))
                        : ((a[W-1] == b[W-1]) && (full[W-1] != a[W-1]));
            bus.in_a = a;
            bus.in_b = b;
            bus.in_sub = sub;
            bus.in_valid = 1'b1;
            bus.out_ready = 1'($urandom_range(0, 1));
            n_checks++;
            if (bus.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b%0d_ready: rdy=%b, expected 1", i, bus.in_ready);
            end
            step();
            bus.in_valid = 1'b0;
            done = 1'b0;
            for (int c = 0; c < 200 && !done; c++) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                if (bus.out_valid && bus.out_ready) begin
                    done = 1'b1;
                    n_checks++;
                    if ({bus.out_sum, bus.out_carry, bus.out_ovf} !== {full[W-1:0], full[W], exp_v}) begin
                        n_fail++;
                        $display("FAIL b2b%0d_result: a=%h b=%h sub=%b got sum=%h c=%b v=%b, expected sum=%h c=%b v=%b",
                                 i, a, b, sub, bus.out_sum, bus.out_carry, bus.out_ovf, full[W-1:0], full[W], exp_v);
                    end
                end
                step();
            end
            if (!done) begin
                n_checks++;
                n_fail++;
                $display("FAIL b2b%0d_timeout: no out_valid within 200 cycles, expected one", i);
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_sub = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_vectors();
        test_backpressure();
        test_rst_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
